// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: core stores to TX_ADDR are queued in a FIFO and sent as 8N1 frames.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
    parameter logic [31:0] TX_ADDR      = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        write_enab,
    input  logic [31:0]                 data_addr,
    input  logic [31:0]                 write_data,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [7:0]                  overflow_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_idx, bit_next;
    logic [7:0]       shreg;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count_next;
    logic             bit_end, pop, push_req, push_ok, tx_next;
    logic             unused_bits;

    assign unused_bits = ^write_data[31:8];
    assign push_req    = write_enab && (data_addr == TX_ADDR);
    // A full FIFO still accepts a byte when the FSM pops in the same cycle.
    assign push_ok     = push_req && ((fifo_count < DEPTH_C) || pop);
    assign count_next  = fifo_count + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop};

    always_comb begin
        state_next = state;
        cnt_next   = cnt + CNT_W'(1);
        bit_next   = bit_idx;
        pop        = 1'b0;
        bit_end    = (cnt == CNT_MAX);
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (fifo_count != '0) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        bit_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    cnt_next = '0;
                    if (fifo_count != '0) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // The line level is derived from the state being entered so tx is a clean register output.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg[bit_next];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = ^shreg;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            bit_idx        <= '0;
            shreg          <= '0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            fifo_count     <= '0;
            overflow_count <= '0;
            tx             <= 1'b1;
            busy           <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            bit_idx    <= bit_next;
            fifo_count <= count_next;
            tx         <= tx_next;
            busy       <= (state_next != IDLE) || (count_next != '0);
            if (pop) begin
                shreg  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (push_req && !push_ok && overflow_count != 8'hFF)
                overflow_count <= overflow_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= write_data[7:0];
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: stimulus queues expected bytes, a line monitor decodes frames and compares.
module tb_mmio_uart_tx;
    localparam int          CPB     = 4;
    localparam int          DEPTH   = 8;
    localparam logic [31:0] TX_ADDR = 32'h0000_1000;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write_enab = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] write_data = '0;
    logic        tx, busy;
    logic [3:0]  fifo_count;
    logic [7:0]  overflow_count;

    int         tests = 0;
    int         fails = 0;
    int         cycle = 0;
    logic       mon_en = 1'b1;
    logic [7:0] exp_q[$];
    int         start_q[$];

    mmio_uart_tx #(.TX_ADDR(TX_ADDR), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .write_enab(write_enab), .data_addr(data_addr),
        .write_data(write_data), .tx(tx), .busy(busy), .fifo_count(fifo_count),
        .overflow_count(overflow_count)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        write_enab = we;
        data_addr  = addr;
        write_data = data;
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_busy", 32'(busy), 32'd0);
        checkOutput("drain_queue", 32'(exp_q.size()), 32'd0);
    endtask

    // Line monitor: every bit of every frame is sampled each cycle so timing slips are caught too.
    initial begin : monitor
        logic [7:0]  exp_byte;
        logic [10:0] exp_vec, got_vec;
        logic        stable, aborted;
        forever begin
            @(negedge clk);
            if (mon_en && !reset && tx === 1'b0) begin
                start_q.push_back(cycle);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_frame: start bit at cycle %0d, expected idle line", cycle);
                    repeat (FRAME - 1) @(negedge clk);
                end else begin
                    exp_byte = exp_q.pop_front();
                    exp_vec  = '0;
                    exp_vec[8:1] = exp_byte;
`ifdef UART_TX_PARITY_EN
                    exp_vec[9]  = ^exp_byte;
                    exp_vec[10] = 1'b1;
`else
                    exp_vec[9]  = 1'b1;
`endif
                    got_vec = '0;
                    stable  = 1'b1;
                    aborted = 1'b0;
                    for (int k = 0; k < FRAME; k++) begin
                        if (k > 0) @(negedge clk);
                        if (reset) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (k % CPB == CPB / 2) got_vec[k / CPB] = tx;
                        if (tx !== exp_vec[k / CPB]) stable = 1'b0;
                    end
                    if (!aborted) begin
                        checkOutput("frame_bits", 32'(got_vec), 32'(exp_vec));
                        checkOutput("frame_timing", 32'(stable), 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        checkOutput("reset_tx", 32'(tx), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_count", 32'(fifo_count), 32'd0);
        checkOutput("reset_overflow", 32'(overflow_count), 32'd0);
        reset = 1'b0;

        // Single byte 0x55: start, 1010_1010 LSB first, stop.
        exp_q.push_back(8'h55);
        applyStimulus(1'b1, TX_ADDR, 32'hDEADBE55);
        applyStimulus(1'b0, 32'h0, 32'h0);
        checkOutput("e0_count", 32'(fifo_count), 32'd1);
        checkOutput("e0_busy", 32'(busy), 32'd1);
        checkOutput("e0_tx", 32'(tx), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0);
        checkOutput("e1_count", 32'(fifo_count), 32'd0);
        checkOutput("e1_tx", 32'(tx), 32'd0);
        n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("busy_frame_len", 32'(n), 32'(FRAME));
        waitDrain(100);

        // Address filter.
        applyStimulus(1'b1, TX_ADDR + 32'd4, 32'h11);
        applyStimulus(1'b1, 32'd100, 32'h22);
        applyStimulus(1'b0, TX_ADDR, 32'h33);
        applyStimulus(1'b0, 32'h0, 32'h0);
        checkOutput("filter_count", 32'(fifo_count), 32'd0);
        checkOutput("filter_tx", 32'(tx), 32'd1);
        checkOutput("filter_busy", 32'(busy), 32'd0);

        // Overflow: 10 stores back to back, the 10th is dropped.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, TX_ADDR, 32'(8'h30 + i));
            if (i < 9) exp_q.push_back(8'(8'h30 + i));
            if (i == 9) checkOutput("ovf_full_count", 32'(fifo_count), 32'd8);
        end
        applyStimulus(1'b0, 32'h0, 32'h0);
        checkOutput("ovf_count", 32'(overflow_count), 32'd1);
        checkOutput("ovf_still_full", 32'(fifo_count), 32'd8);
        waitDrain(9 * FRAME + 50);

        // Back-to-back frames must be contiguous.
        start_q.delete();
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        applyStimulus(1'b1, TX_ADDR, 32'h41);
        applyStimulus(1'b1, TX_ADDR, 32'h42);
        applyStimulus(1'b0, 32'h0, 32'h0);
        waitDrain(2 * FRAME + 50);
        checkOutput("b2b_frames", 32'(start_q.size()), 32'd2);
        if (start_q.size() == 2)
            checkOutput("b2b_gap", 32'(start_q[1] - start_q[0]), 32'(FRAME));

        // Reset during DATA bit 3 with two bytes still queued.
        mon_en = 1'b0;
        applyStimulus(1'b1, TX_ADDR, 32'h11);
        applyStimulus(1'b1, TX_ADDR, 32'h22);
        applyStimulus(1'b1, TX_ADDR, 32'h33);
        applyStimulus(1'b0, 32'h0, 32'h0);
        repeat (16) @(negedge clk);
        checkOutput("pre_reset_count", 32'(fifo_count), 32'd2);
        checkOutput("pre_reset_tx", 32'(tx), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("mid_reset_tx", 32'(tx), 32'd1);
        checkOutput("mid_reset_count", 32'(fifo_count), 32'd0);
        checkOutput("mid_reset_busy", 32'(busy), 32'd0);
        checkOutput("mid_reset_overflow", 32'(overflow_count), 32'd0);
        n = 0;
        repeat (3 * FRAME) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) n++;
        end
        checkOutput("post_reset_quiet", 32'(n), 32'd0);
        mon_en = 1'b1;

        // Parity-sensitive bytes: 0x07 has odd weight, 0x03 even.
        exp_q.push_back(8'h07);
        exp_q.push_back(8'h03);
        applyStimulus(1'b1, TX_ADDR, 32'h07);
        applyStimulus(1'b1, TX_ADDR, 32'h03);
        applyStimulus(1'b0, 32'h0, 32'h0);
        waitDrain(2 * FRAME + 50);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the data-memory write side of the single-cycle core. It consumes the core's `write_enab` / `data_addr` / `write_data` outputs and captures byte writes to one fixed address into a small FIFO. It serializes the captured bytes on an 8N1 line. Benches and boards use it as the program's character output port without changing the core.

## Interface

Parameters:
- `TX_ADDR`, default 32'h0000_1000: byte-write target address.
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit; must be ≥ 2.
- `FIFO_DEPTH`, default 8: FIFO entries; must be a power of two, ≥ 2.

Ports:
- `clk` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `write_enab` input 1: core store strobe.
- `data_addr` input 32: core store address.
- `write_data` input 32: core store data; only bits [7:0] are used.
- `tx` output 1: serial line, registered, idles high.
- `busy` output 1: high when the FSM is not IDLE or the FIFO is non-empty.
- `fifo_count` output $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `overflow_count` output 8: number of dropped writes, saturating at 8'hFF.

## Operation

- **Capture.** A push request is `write_enab && data_addr == TX_ADDR`, with a full 32-bit compare. Writes to any other address are ignored.
- **Push accept.** A push is accepted if `fifo_count < FIFO_DEPTH`, or if a pop occurs in the same cycle.
- **Drop.** Otherwise the push is dropped and `overflow_count` increments, saturating at 8'hFF.
- **FIFO.** Circular buffer with wrap-around read/write pointers. There is no fall-through: a byte pushed at edge N can be popped at edge N+1 at the earliest.
- **Simultaneous push and pop.** `fifo_count` is unchanged.
- **FSM states:** IDLE, START, DATA, STOP (plus PARITY when configured).
  - IDLE: `tx`=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; a 3-bit bit index counts them. After bit 7, go to STOP (or PARITY).
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START; otherwise go to IDLE.
- **Counters.** The bit-period counter counts 0..CLKS_PER_BIT-1 and clears on every state transition.
- **Reset.** Values on the edge where `reset` is sampled high:
  - `tx`=1, `busy`=0, `fifo_count`=0, `overflow_count`=0.
  - FSM in IDLE; pointers and counters cleared.
- **Reset mid-frame.** The frame is aborted, the FIFO contents are discarded, and `tx` is high from the next edge.

## Timing

- Write sampled at edge E0 (FSM in IDLE, FIFO empty): `fifo_count`=1 after E0.
- At edge E1 the byte is popped and `tx` falls; `fifo_count` returns to 0 after E1.
- Frame length is exactly 10×CLKS_PER_BIT cycles (11× with parity), from the falling edge of `tx` at E1 to the end of the stop bit.
- Back-to-back frames have zero idle cycles between the stop bit and the next start bit.
- `busy` is registered and asserts after E0.
- `busy` deasserts on the edge at which STOP exits to IDLE with the FIFO empty.
- The core may store every cycle. Sustained input faster than the line rate fills the FIFO and then drops bytes; the block never stalls the core.

## Configuration

- `UART_TX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame becomes 11 bits.
- `UART_TX_PARITY_EN` undefined:
  - The PARITY state and its logic are absent.
  - Frame is 8N1, 10 bits.

## Test plan

- **Single byte.** CLKS_PER_BIT=4; store 32'hDEADBE55 to TX_ADDR.
  - `tx` is low for 4 cycles from E1.
  - Then 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4 cycles.
  - `busy` drops after 40 cycles of frame.
- **Address filter.** Stores to TX_ADDR+4 and to address 100, plus a read (`write_enab`=0) at TX_ADDR.
  - `fifo_count` stays 0 and `tx` stays 1.
- **Overflow.** FIFO_DEPTH=8; 10 stores to TX_ADDR on consecutive cycles E0..E9.
  - 9 bytes accepted (one is popped at E1).
  - `fifo_count`=8 after E8.
  - `overflow_count`=1 after E9.
  - 9 frames are emitted in order.
- **Back-to-back.** Stores of 8'h41 and 8'h42 in consecutive cycles.
  - Two frames are contiguous: 20×CLKS_PER_BIT cycles with no idle gap.
  - The second start bit begins the cycle after the first stop bit.
- **Reset mid-frame.** Assert `reset` during DATA bit 3 with 2 bytes queued.
  - After that edge: `tx`=1, `fifo_count`=0, `busy`=0.
  - No further frames are emitted.
- **Parity** (`UART_TX_PARITY_EN` defined).
  - Byte 8'h07: parity bit 1.
  - Byte 8'h03: parity bit 0.
  - Frame is 44 cycles at CLKS_PER_BIT=4.
